rv_data_memory: RTL and testbench
=================================

Name: rv_data_memory

Overview:
- Parametrised, handshaked data memory for the RISC-V core's load/store unit.
- Successor to the fixed 1 KiB byte/word memory. Adds:
  - configurable depth;
  - byte, half and word access sizes with byte-lane write enables;
  - signed and unsigned load extension;
  - misalignment detection;
  - programmable wait states behind a valid/ready request and valid response handshake.
- Sits between the core's memory stage and the system bus, one outstanding request at a time.

Parameters:
- ADDR_WIDTH, 12: byte-address width. Depth is 2^ADDR_WIDTH bytes, stored as 2^(ADDR_WIDTH-2) 32-bit words with 4 byte lanes.
- WAIT_STATES, 0: extra cycles inserted before the response. Legal range 0..15.
- INIT_FILE, "": hex file loaded at elaboration when non-empty. Word-organised, little-endian.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_error  out  1  misaligned or illegal-size request.

Behaviour:
- Reset values:
  - state = IDLE; wait counter = 0;
  - rsp_valid = 0, rsp_rdata = 0, rsp_error = 0;
  - req_ready = 0 while reset is high;
  - memory contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
  - req_ready = (state == IDLE) && !reset.
  - Accept = req_valid && req_ready.
  - IDLE → WAIT on accept when WAIT_STATES > 0; counter loads WAIT_STATES-1.
  - IDLE → RESP on accept when WAIT_STATES == 0.
  - WAIT decrements the counter each cycle; moves to RESP on the cycle the counter reads 0.
  - RESP asserts rsp_valid for exactly one cycle, then returns to IDLE. No back-to-back acceptance in RESP.
- Latency: accepted at edge N → rsp_valid high in cycle N+1+WAIT_STATES. Throughput is one request per 2+WAIT_STATES cycles.
- Request capture:
  - req_write, req_addr, req_size, req_unsigned and req_wdata are registered at acceptance.
  - Inputs are ignored until back in IDLE.
- Error detection (captured at acceptance):
  - error = (size == 11) || (size == 01 && addr[0]) || (size == 10 && addr[1:0] != 0).
  - An erroring store writes nothing.
  - An erroring load returns rdata = 0.
  - rsp_error is valid only with rsp_valid and is 0 otherwise.
- Stores:
  - Committed to the array at the acceptance edge, using byte enables derived from size and addr[1:0]. Little-endian lanes.
  - Byte: lane addr[1:0] ← wdata[7:0].
  - Half: lanes addr[1]*2 and addr[1]*2+1 ← wdata[15:0].
  - Word: all lanes.
  - Untouched lanes keep their values.
- Loads:
  - The word at addr[ADDR_WIDTH-1:2] is read and registered into rsp_rdata on entry to RESP, so stores completed earlier are always visible.
  - The selected lane(s) are shifted to bit 0, then sign- or zero-extended to 32 bits per req_unsigned.
  - req_unsigned is ignored for word loads.
- Address wrap: the address is used modulo 2^ADDR_WIDTH; no bits are dropped beyond that.
- Reset mid-operation: any pending request is abandoned and no response is issued. A store committed at acceptance remains in memory.
- rsp_rdata and rsp_error hold their last value outside RESP; the bench must only sample them when rsp_valid = 1.

Decomposition:
- Shared package mem_pkg contains:
  - mem_size_t enum: MEM_BYTE, MEM_HALF, MEM_WORD, MEM_ILLEGAL;
  - memory FSM state enum;
  - WAIT_STATES_MAX = 15 constant.
- One combinational sub-module, lsu_align, handles:
  - byte-enable generation;
  - store lane steering;
  - misalignment/illegal detection;
  - load lane extraction and extension.
- The top level keeps the array, FSM, wait counter and response registers.

Test Plan:
- WAIT_STATES = 0: store word 0xDEADBEEF @0x010, then load word @0x010 → rsp_valid exactly 1 cycle after each acceptance; rdata = 0xDEADBEEF, error = 0.
- Byte loads after that store: @0x013 signed → 0xFFFFFFDE; @0x013 unsigned → 0x000000DE; @0x010 signed → 0xFFFFFFEF.
- Half store 0x1234 @0x012, then word load @0x010 → 0x1234BEEF (lower lanes untouched); signed half load @0x012 → 0x00001234.
- Misaligned requests: word store 0xAAAAAAAA @0x011, half load @0x013, size=11 @0x020 → each rsp_error = 1, rdata = 0; word @0x010 still 0x1234BEEF.
- WAIT_STATES = 3: load accepted at cycle 10 → req_ready low cycles 11..14; rsp_valid only in cycle 14; req_ready high again in cycle 15; a second req_valid held high is accepted at 15.
- Reset asserted in WAIT after a word store 0x5555AAAA @0x040 → no rsp_valid; all outputs 0 next cycle; a later load @0x040 returns 0x5555AAAA.

Source files
------------

// File: rtl/mem_pkg.sv
// ============================================================================
// Module  : mem_pkg
// Purpose : Shared types and constants for the rv_data_memory slice.
//           - mem_size_t : access size encoding carried on req_size
//           - mem_state_t: request/response FSM states
//           - WAIT_STATES_MAX: largest wait-state count the counter can hold
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE    = 2'b00,
    MEM_HALF    = 2'b01,
    MEM_WORD    = 2'b10,
    MEM_ILLEGAL = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } mem_state_t;

  localparam int WAIT_STATES_MAX = 15;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module  : lsu_align
// Purpose : Combinational lane logic for the data memory.
//           Generates byte enables and steered store data, flags misaligned
//           or illegal-size accesses, and extracts/extends load data.
// Ports   : size          in  2   access size (mem_size_t encoding)
//           addr_lo       in  2   byte offset within the word
//           load_unsigned in  1   1 = zero-extend, 0 = sign-extend
//           wdata         in  32  right-aligned store data
//           rword         in  32  raw word read from the array
//           byte_en       out 4   per-lane write enables (0 on error)
//           wdata_lanes   out 32  store data replicated onto every lane
//           error         out 1   misaligned or illegal-size access
//           rdata         out 32  extended load data (0 on error)
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        load_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic        error,
  output logic [31:0] rdata
);

  mem_size_t   w_size;
  logic [31:0] w_shifted;

  assign w_size = mem_size_t'(size);

  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = wdata;
    error       = 1'b0;
    rdata       = 32'h0;
    // Bring the addressed lane(s) down to bit 0 before extension.
    w_shifted   = rword >> {addr_lo, 3'b000};

    case (w_size)
      MEM_BYTE: begin
        byte_en     = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        rdata       = load_unsigned ? {24'h0, w_shifted[7:0]}
                                    : {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      MEM_HALF: begin
        error       = addr_lo[0];
        byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        rdata       = load_unsigned ? {16'h0, w_shifted[15:0]}
                                    : {{16{w_shifted[15]}}, w_shifted[15:0]};
      end
      MEM_WORD: begin
        error   = (addr_lo != 2'b00);
        byte_en = 4'b1111;
        rdata   = w_shifted;
      end
      default: begin
        error = 1'b1;
      end
    endcase

    // An erroring access neither writes nor returns data.
    if (error) begin
      byte_en = 4'b0000;
      rdata   = 32'h0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rv_data_memory.sv
// ============================================================================
// Module  : rv_data_memory
// Purpose : Handshaked byte/half/word data memory for the load/store unit,
//           one outstanding request, programmable wait states.
// Ports   : clock        in  1           rising-edge clock
//           reset        in  1           synchronous active-high reset
//           req_valid    in  1           request present
//           req_ready    out 1           block can accept a request
//           req_write    in  1           1 = store, 0 = load
//           req_addr     in  ADDR_WIDTH  byte address
//           req_size     in  2           00 byte, 01 half, 10 word, 11 illegal
//           req_unsigned in  1           loads: 1 = zero-extend
//           req_wdata    in  32          right-aligned store data
//           rsp_valid    out 1           one-cycle response pulse
//           rsp_rdata    out 32          extended load data
//           rsp_error    out 1           misaligned / illegal request
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module rv_data_memory
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0,
  parameter     INIT_FILE   = ""
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error
);

  localparam int         DEPTH_WORDS = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0] c_wait_load = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [31:0] r_mem [DEPTH_WORDS];

  mem_state_t            r_state;
  logic [3:0]            r_wait_cnt;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic                  r_rsp_valid;
  logic [31:0]           r_rsp_rdata;
  logic                  r_rsp_error;

  logic                  w_idle;
  logic                  w_accept;
  logic                  w_enter_resp;
  logic                  w_sel_write;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [1:0]            w_sel_size;
  logic                  w_sel_unsigned;
  logic [31:0]           w_rword;
  logic [3:0]            w_byte_en;
  logic [31:0]           w_wdata_lanes;
  logic                  w_error;
  logic [31:0]           w_load_data;

  assign w_idle    = (r_state == ST_IDLE);
  assign req_ready = w_idle && !reset;
  assign w_accept  = req_valid && req_ready;

  // In IDLE the live request drives the lane logic (store commit and, with
  // zero wait states, the load read); afterwards the captured copy does.
  assign w_sel_write    = w_idle ? req_write    : r_write;
  assign w_sel_addr     = w_idle ? req_addr     : r_addr;
  assign w_sel_size     = w_idle ? req_size     : r_size;
  assign w_sel_unsigned = w_idle ? req_unsigned : r_unsigned;

  assign w_rword = r_mem[w_sel_addr[ADDR_WIDTH-1:2]];

  assign w_enter_resp = (w_accept && (WAIT_STATES == 0)) ||
                        ((r_state == ST_WAIT) && (r_wait_cnt == 4'd0));

  lsu_align u_align (
    .size          (w_sel_size),
    .addr_lo       (w_sel_addr[1:0]),
    .load_unsigned (w_sel_unsigned),
    .wdata         (req_wdata),
    .rword         (w_rword),
    .byte_en       (w_byte_en),
    .wdata_lanes   (w_wdata_lanes),
    .error         (w_error),
    .rdata         (w_load_data)
  );

  // Stores commit at the acceptance edge; the array is never cleared.
  always_ff @(posedge clock) begin
    if (w_accept && req_write) begin
      for (int i = 0; i < 4; i++) begin
        if (w_byte_en[i]) begin
          r_mem[req_addr[ADDR_WIDTH-1:2]][8*i +: 8] <= w_wdata_lanes[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= 4'd0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_error <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_write    <= req_write;
            r_addr     <= req_addr;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            if (WAIT_STATES == 0) begin
              r_state <= ST_RESP;
            end else begin
              r_state    <= ST_WAIT;
              r_wait_cnt <= c_wait_load;
            end
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            r_state <= ST_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      // Response is built from the array as it stands on entry to RESP.
      if (w_enter_resp) begin
        r_rsp_valid <= 1'b1;
        r_rsp_error <= w_error;
        r_rsp_rdata <= (w_error || w_sel_write) ? 32'h0 : w_load_data;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_error = r_rsp_error && r_rsp_valid;

endmodule

`default_nettype wire

// File: tb/tb_rv_data_memory.sv
`default_nettype none

module tb_rv_data_memory;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_write = 1'b0;
  logic [11:0] req_addr = '0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;

  logic        valid0 = 1'b0, ready0, rsp_valid0, rsp_error0;
  logic [31:0] rsp_rdata0;
  logic        valid3 = 1'b0, ready3, rsp_valid3, rsp_error3;
  logic [31:0] rsp_rdata3;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  rv_data_memory #(.ADDR_WIDTH(12), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
    .clock(clock), .reset(reset), .req_valid(valid0), .req_ready(ready0),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_error(rsp_error0)
  );

  rv_data_memory #(.ADDR_WIDTH(12), .WAIT_STATES(3), .INIT_FILE("")) dut3 (
    .clock(clock), .reset(reset), .req_valid(valid3), .req_ready(ready3),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_error(rsp_error3)
  );

  // Issues one request to dut0 (sel=0) or dut3 (sel=1) and returns the
  // response; lat counts edges from acceptance to rsp_valid (-1 = timeout),
  // one_cycle reports whether rsp_valid dropped on the following cycle.
  // Called and returns at 1 time unit after a rising edge.
  task automatic do_req(input bit sel, input bit wr, input logic [11:0] addr,
                        input logic [1:0] size, input bit uns, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output bit one_cycle);
    int n;
    req_write = wr; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    if (sel) valid3 = 1'b1; else valid0 = 1'b1;
    n = 0;
    while (!(sel ? ready3 : ready0) && n < 20) begin
      @(posedge clock); #1; n++;
    end
    @(posedge clock); #1;
    valid0 = 1'b0; valid3 = 1'b0;
    lat = 0;
    while (!(sel ? rsp_valid3 : rsp_valid0) && lat < 40) begin
      @(posedge clock); #1; lat++;
    end
    if (lat >= 40) lat = -1;
    rdata = sel ? rsp_rdata3 : rsp_rdata0;
    err   = sel ? rsp_error3 : rsp_error0;
    @(posedge clock); #1;
    one_cycle = !(sel ? rsp_valid3 : rsp_valid0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (ready0 !== 1'b0 || ready3 !== 1'b0) begin
      failures++; $display("FAIL reset_ready: got %b/%b need 0/0", ready0, ready3);
    end
    checks++;
    if ({rsp_valid0, rsp_error0, rsp_valid3, rsp_error3} !== 4'b0000) begin
      failures++; $display("FAIL reset_rsp_flags: got %b%b%b%b need 0000",
                           rsp_valid0, rsp_error0, rsp_valid3, rsp_error3);
    end
    checks++;
    if (rsp_rdata0 !== 32'h0 || rsp_rdata3 !== 32'h0) begin
      failures++; $display("FAIL reset_rdata: got %h/%h need 0", rsp_rdata0, rsp_rdata3);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ready0 !== 1'b1 || ready3 !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready: got %b/%b need 1/1", ready0, ready3);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat; bit oc;
    do_req(0, 1, 12'h010, 2'b10, 0, 32'hDEADBEEF, rd, er, lat, oc);
    checks++;
    if (lat !== 0 || !oc) begin
      failures++; $display("FAIL word_store_timing: lat=%0d one_cycle=%0b need 0/1", lat, oc);
    end
    checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      failures++; $display("FAIL word_store_rsp: err=%b rdata=%h need 0/00000000", er, rd);
    end
    do_req(0, 0, 12'h010, 2'b10, 0, 32'h0, rd, er, lat, oc);
    checks++;
    if (lat !== 0 || !oc) begin
      failures++; $display("FAIL word_load_timing: lat=%0d one_cycle=%0b need 0/1", lat, oc);
    end
    checks++;
    if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      failures++; $display("FAIL word_load: err=%b rdata=%h need 0/deadbeef", er, rd);
    end
  endtask

  task automatic test_byte_loads();
    logic [31:0] rd; logic er; int lat; bit oc;
    do_req(0, 0, 12'h013, 2'b00, 0, 32'h0, rd, er, lat, oc);
    checks++;
    if (er !== 1'b0 || rd !== 32'hFFFFFFDE) begin
      failures++; $display("FAIL byte_013_signed: err=%b rdata=%h need 0/ffffffde", er, rd);
    end
    do_req(0, 0, 12'h013, 2'b00, 1, 32'h0, rd, er, lat, oc);
    checks++;
    if (er !== 1'b0 || rd !== 32'h000000DE) begin
      failures++; $display("FAIL byte_013_unsigned: err=%b rdata=%h need 0/000000de", er, rd);
    end
    do_req(0, 0, 12'h010, 2'b00, 0, 32'h0, rd, er, lat, oc);
    checks++;
    if (er !== 1'b0 || rd !== 32'hFFFFFFEF) begin
      failures++; $display("FAIL byte_010_signed: err=%b rdata=%h need 0/ffffffef", er, rd);
    end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat; bit oc;
    do_req(0, 1, 12'h012, 2'b01, 0, 32'h00001234, rd, er, lat, oc);
    checks++;
    if (er !== 1'b0) begin
      failures++; $display("FAIL half_store_err: err=%b need 0", er);
    end
    do_req(0, 0, 12'h010, 2'b10, 0, 32'h0, rd, er, lat, oc);
    checks++;
    if (rd !== 32'h1234BEEF) begin
      failures++; $display("FAIL half_merge_word: rdata=%h need 1234beef", rd);
    end
    do_req(0, 0, 12'h012, 2'b01, 0, 32'h0, rd, er, lat, oc);
    checks++;
    if (er !== 1'b0 || rd !== 32'h00001234) begin
      failures++; $display("FAIL half_load_signed: err=%b rdata=%h need 0/00001234", er, rd);
    end
    do_req(0, 0, 12'h010, 2'b01, 1, 32'h0, rd, er, lat, oc);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0000BEEF) begin
      failures++; $display("FAIL half_load_unsigned: err=%b rdata=%h need 0/0000beef", er, rd);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er; int lat; bit oc;
    do_req(0, 1, 12'h011, 2'b10, 0, 32'hAAAAAAAA, rd, er, lat, oc);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("FAIL mis_word_store: err=%b rdata=%h need 1/0", er, rd);
    end
    do_req(0, 0, 12'h013, 2'b01, 0, 32'h0, rd, er, lat, oc);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("FAIL mis_half_load: err=%b rdata=%h need 1/0", er, rd);
    end
    do_req(0, 0, 12'h020, 2'b11, 0, 32'h0, rd, er, lat, oc);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("FAIL illegal_size: err=%b rdata=%h need 1/0", er, rd);
    end
    do_req(0, 0, 12'h010, 2'b10, 0, 32'h0, rd, er, lat, oc);
    checks++;
    if (er !== 1'b0 || rd !== 32'h1234BEEF) begin
      failures++; $display("FAIL mis_no_write: err=%b rdata=%h need 0/1234beef", er, rd);
    end
  endtask

  // Cycle numbering: the acceptance edge ends cycle 10.
  task automatic test_wait_states();
    int n;
    req_write = 1'b0; req_addr = 12'h010; req_size = 2'b10; req_unsigned = 1'b0;
    valid3 = 1'b1;
    checks++;
    if (ready3 !== 1'b1) begin
      failures++; $display("FAIL ws_ready_idle: got %b need 1", ready3);
    end
    @(posedge clock); #1;                       // accepted; now cycle 11
    for (int c = 11; c <= 14; c++) begin
      checks++;
      if (ready3 !== 1'b0) begin
        failures++; $display("FAIL ws_ready_busy c%0d: got %b need 0", c, ready3);
      end
      checks++;
      if (rsp_valid3 !== (c == 14)) begin
        failures++; $display("FAIL ws_rsp_valid c%0d: got %b need %b", c, rsp_valid3, c == 14);
      end
      @(posedge clock); #1;
    end
    checks++;                                   // cycle 15
    if (ready3 !== 1'b1 || rsp_valid3 !== 1'b0) begin
      failures++; $display("FAIL ws_c15: ready=%b rsp_valid=%b need 1/0", ready3, rsp_valid3);
    end
    @(posedge clock); #1;                       // held request accepted at 15
    valid3 = 1'b0;
    checks++;
    if (ready3 !== 1'b0) begin
      failures++; $display("FAIL ws_second_accept: ready=%b need 0", ready3);
    end
    n = 0;
    while (!rsp_valid3 && n < 20) begin
      @(posedge clock); #1; n++;
    end
    checks++;
    if (n !== 3) begin
      failures++; $display("FAIL ws_second_latency: edges=%0d need 3", n);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; bit oc; bit seen;
    req_write = 1'b1; req_addr = 12'h040; req_size = 2'b10;
    req_unsigned = 1'b0; req_wdata = 32'h5555AAAA;
    valid3 = 1'b1;
    @(posedge clock); #1;                       // accepted, now in WAIT
    valid3 = 1'b0;
    seen = rsp_valid3;
    @(posedge clock); #1;
    seen = seen | rsp_valid3;
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if ({ready3, rsp_valid3, rsp_error3} !== 3'b000 || rsp_rdata3 !== 32'h0) begin
      failures++; $display("FAIL mid_reset_outputs: ready=%b valid=%b err=%b rdata=%h need all 0",
                           ready3, rsp_valid3, rsp_error3, rsp_rdata3);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      seen = seen | rsp_valid3;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL mid_reset_no_rsp: rsp_valid seen=%b need 0", seen);
    end
    do_req(1, 0, 12'h040, 2'b10, 0, 32'h0, rd, er, lat, oc);
    checks++;
    if (er !== 1'b0 || rd !== 32'h5555AAAA || lat !== 3) begin
      failures++; $display("FAIL mid_reset_store_kept: err=%b rdata=%h lat=%0d need 0/5555aaaa/3",
                           er, rd, lat);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_loads();
    test_half();
    test_misaligned();
    test_wait_states();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
